// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin arbiter and access sequencer in front of a word-wide data memory.
// Sub-word stores are read-modify-write; sub-word loads are zero-extended.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [1:0]            r0_mode,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [31:0]           r0_wdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [1:0]            r1_mode,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [31:0]           r1_wdata,
  output logic                  done0,
  output logic                  done1,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-3:0] m_addr,
  output logic [31:0]           m_wdata,
  output logic                  m_we,
  input  logic [31:0]           m_rdata
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t            state, state_d;
  logic              last_grant, last_grant_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        lo_q, lo_d;
  logic [15:0]       wd_q, wd_d;
  logic              fault_q, fault_d;

  logic              done0_d, done1_d, err_d, busy_d, m_we_d;
  logic [31:0]       rdata_d, m_wdata_d;
  logic [IDX_W-1:0]  m_addr_d;

  logic                  gnt_c;
  logic                  sel_we_c;
  logic [1:0]            sel_mode_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [31:0]           sel_wdata_c;
  logic                  sel_fault_c;

  // Reserved size, odd halfword, or non-word-aligned word.
  function automatic logic is_fault(input logic [1:0] mode, input logic [1:0] lo);
    logic f;
    case (mode)
      2'b00:   f = 1'b0;
      2'b01:   f = lo[0];
      2'b10:   f = (lo != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [31:0] load_field(input logic [1:0] mode, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [31:0] f;
    f = w;
    case (mode)
      2'b00: begin
        case (lo)
          2'd0:    f = {24'd0, w[7:0]};
          2'd1:    f = {24'd0, w[15:8]};
          2'd2:    f = {24'd0, w[23:16]};
          default: f = {24'd0, w[31:24]};
        endcase
      end
      2'b01:   f = lo[1] ? {16'd0, w[31:16]} : {16'd0, w[15:0]};
      default: f = w;
    endcase
    return f;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [1:0] mode, input logic [1:0] lo,
                                             input logic [31:0] w, input logic [15:0] d);
    logic [31:0] m;
    m = w;
    case (mode)
      2'b00: begin
        case (lo)
          2'd0:    m = {w[31:8], d[7:0]};
          2'd1:    m = {w[31:16], d[7:0], w[7:0]};
          2'd2:    m = {w[31:24], d[7:0], w[15:0]};
          default: m = {d[7:0], w[23:0]};
        endcase
      end
      2'b01:   m = lo[1] ? {d[15:0], w[15:0]} : {w[31:16], d[15:0]};
      default: m = w;
    endcase
    return m;
  endfunction

  // Round-robin pick: a tie goes to the port that did not win last time.
  always_comb begin
    gnt_c       = r0_req ? (r1_req & ~last_grant) : 1'b1;
    sel_we_c    = gnt_c ? r1_we    : r0_we;
    sel_mode_c  = gnt_c ? r1_mode  : r0_mode;
    sel_addr_c  = gnt_c ? r1_addr  : r0_addr;
    sel_wdata_c = gnt_c ? r1_wdata : r0_wdata;
    sel_fault_c = is_fault(sel_mode_c, sel_addr_c[1:0]);
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    gnt_d        = gnt_q;
    we_d         = we_q;
    mode_d       = mode_q;
    lo_d         = lo_q;
    wd_d         = wd_q;
    fault_d      = fault_q;
    rdata_d      = rdata;
    m_addr_d     = m_addr;
    m_wdata_d    = m_wdata;
    m_we_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = 1'b0;
    busy_d       = 1'b0;

    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          state_d      = ACCESS;
          last_grant_d = gnt_c;
          gnt_d        = gnt_c;
          we_d         = sel_we_c;
          mode_d       = sel_mode_c;
          lo_d         = sel_addr_c[1:0];
          wd_d         = sel_wdata_c[15:0];
          fault_d      = sel_fault_c;
          m_addr_d     = sel_addr_c[ADDR_WIDTH-1:2];
          // Word store writes during ACCESS, so its strobe and data are set up now.
          if (sel_we_c && (sel_mode_c == 2'b10) && !sel_fault_c) begin
            m_we_d    = 1'b1;
            m_wdata_d = sel_wdata_c;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (fault_q) begin
          rdata_d = 32'd0;
        end else if (!we_q) begin
          rdata_d = load_field(mode_q, lo_q, m_rdata);
        end else if (mode_q == 2'b10) begin
          rdata_d = 32'd0;
        end else begin
          state_d   = MERGE;
          m_we_d    = 1'b1;
          m_wdata_d = merge_lane(mode_q, lo_q, m_rdata, wd_q);
        end
      end
      MERGE: begin
        state_d = RESP;
        rdata_d = 32'd0;
      end
      RESP: begin
        state_d  = IDLE;
        m_addr_d = '0;
      end
      default: begin
        state_d  = IDLE;
        m_addr_d = '0;
      end
    endcase

    busy_d  = (state_d != IDLE);
    done0_d = (state_d == RESP) && !gnt_q;
    done1_d = (state_d == RESP) &&  gnt_q;
    err_d   = (state_d == RESP) &&  fault_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      mode_q     <= 2'b00;
      lo_q       <= 2'b00;
      wd_q       <= 16'd0;
      fault_q    <= 1'b0;
      rdata      <= 32'd0;
      m_addr     <= '0;
      m_wdata    <= 32'd0;
      m_we       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      mode_q     <= mode_d;
      lo_q       <= lo_d;
      wd_q       <= wd_d;
      fault_q    <= fault_d;
      rdata      <= rdata_d;
      m_addr     <= m_addr_d;
      m_wdata    <= m_wdata_d;
      m_we       <= m_we_d;
      done0      <= done0_d;
      done1      <= done1_d;
      err        <= err_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural word memory on the memory port.
module tb_dmem_access_ctrl;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          r0_req = 1'b0, r0_we = 1'b0;
  logic [1:0]    r0_mode = 2'b00;
  logic [AW-1:0] r0_addr = '0;
  logic [31:0]   r0_wdata = 32'd0;
  logic          r1_req = 1'b0, r1_we = 1'b0;
  logic [1:0]    r1_mode = 2'b00;
  logic [AW-1:0] r1_addr = '0;
  logic [31:0]   r1_wdata = 32'd0;
  logic          done0, done1, err, busy, m_we;
  logic [31:0]   rdata, m_wdata, m_rdata;
  logic [AW-3:0] m_addr;

  logic [31:0]   mem [0:(1<<(AW-2))-1];
  logic          ld_en = 1'b0;
  logic [AW-3:0] ld_idx = '0;
  logic [31:0]   ld_val = 32'd0;
  int            we_pulses = 0;
  int            we_consec = 0;
  logic          prev_we = 1'b0;

  int errors = 0;
  int checks = 0;

  dmem_access_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .clr_n(clr_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_mode(r0_mode), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_mode(r1_mode), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .done0(done0), .done1(done1), .err(err), .rdata(rdata), .busy(busy),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  assign m_rdata = mem[m_addr];

  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
    else if (ld_en) mem[ld_idx] <= ld_val;
  end

  always @(posedge clk) begin
    if (m_we) we_pulses = we_pulses + 1;
    if (m_we && prev_we) we_consec = we_consec + 1;
    prev_we = m_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] val);
    ld_en  = 1'b1;
    ld_idx = (AW-2)'(idx);
    ld_val = val;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drive(input int port, input logic we, input logic [1:0] mode,
                       input logic [AW-1:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      r0_we = we; r0_mode = mode; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1;
    end else begin
      r1_we = we; r1_mode = mode; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1;
    end
  endtask

  // Single transaction: latency, result, error flag, other port quiet, write-strobe count.
  task automatic txn(input string tag, input int port, input logic we, input logic [1:0] mode,
                     input logic [AW-1:0] addr, input logic [31:0] wdata, input int exp_lat,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_we);
    int cyc, w0;
    logic got, other;
    wait_idle();
    w0 = we_pulses;
    drive(port, we, mode, addr, wdata);
    cyc = 0; got = 1'b0; other = 1'b0;
    while (!got && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      if ((port == 0) ? done0 : done1) got = 1'b1;
      if ((port == 0) ? done1 : done0) other = 1'b1;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_other_done"}, 32'(other), 32'd0);
    chk({tag, "_we_pulses"}, 32'(we_pulses - w0), 32'(exp_we));
    if (port == 0) r0_req = 1'b0; else r1_req = 1'b0;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr_n = 1'b1;
  endtask

  initial begin
    int seq [3];
    logic [31:0] rds [3];
    int n, cyc, w0;

    load(0, 32'h55555555);
    load(1, 32'hDEADBEEF);
    load(3, 32'h11223344);
    load(4, 32'h00000000);
    do_reset();

    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);

    txn("ld_word", 0, 1'b0, 2'b10, 12'h004, 32'd0, 2, 32'hDEADBEEF, 1'b0, 0);
    txn("st_byte", 1, 1'b1, 2'b00, 12'h00E, 32'h000000A5, 3, 32'd0, 1'b0, 1);
    chk("st_byte_mem", mem[3], 32'h11A53344);
    txn("ld_half", 0, 1'b0, 2'b01, 12'h00E, 32'd0, 2, 32'h000011A5, 1'b0, 0);
    txn("ld_byte", 1, 1'b0, 2'b00, 12'h007, 32'd0, 2, 32'h000000DE, 1'b0, 0);

    // Both ports held high from reset: grants must alternate 0,1,0.
    do_reset();
    seq = '{3, 3, 3};
    rds = '{32'd0, 32'd0, 32'd0};
    drive(0, 1'b0, 2'b10, 12'h004, 32'd0);
    drive(1, 1'b0, 2'b10, 12'h00C, 32'd0);
    n = 0; cyc = 0;
    while (n < 3 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done0 || done1) begin
        seq[n] = (done0 && done1) ? 2 : (done1 ? 1 : 0);
        rds[n] = rdata;
        n++;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    chk("rr_count", 32'(n), 32'd3);
    chk("rr_grant0", 32'(seq[0]), 32'd0);
    chk("rr_grant1", 32'(seq[1]), 32'd1);
    chk("rr_grant2", 32'(seq[2]), 32'd0);
    chk("rr_rdata0", rds[0], 32'hDEADBEEF);
    chk("rr_rdata1", rds[1], 32'h11A53344);
    chk("rr_rdata2", rds[2], 32'hDEADBEEF);

    txn("st_mis", 0, 1'b1, 2'b10, 12'h002, 32'h12345678, 2, 32'd0, 1'b1, 0);
    chk("st_mis_mem", mem[0], 32'h55555555);
    txn("ld_pre", 0, 1'b0, 2'b10, 12'h004, 32'd0, 2, 32'hDEADBEEF, 1'b0, 0);
    txn("rsv_mode", 1, 1'b1, 2'b11, 12'h008, 32'hFFFFFFFF, 2, 32'd0, 1'b1, 0);
    txn("ld_half_odd", 0, 1'b0, 2'b01, 12'h005, 32'd0, 2, 32'd0, 1'b1, 0);
    txn("st_word", 0, 1'b1, 2'b10, 12'h010, 32'hCAFEF00D, 2, 32'd0, 1'b0, 1);
    chk("st_word_mem", mem[4], 32'hCAFEF00D);
    txn("st_half", 1, 1'b1, 2'b01, 12'h010, 32'h1234BEEF, 3, 32'd0, 1'b0, 1);
    chk("st_half_mem", mem[4], 32'hCAFEBEEF);

    // Reset while in MERGE must abort the write.
    wait_idle();
    w0 = we_pulses;
    drive(1, 1'b1, 2'b00, 12'h011, 32'h00000077);
    @(posedge clk); #1;
    chk("mrg_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("mrg_m_we", 32'(m_we), 32'd1);
    chk("mrg_m_wdata", m_wdata, 32'hCAFE77EF);
    #1 clr_n = 1'b0;
    r1_req = 1'b0;
    #1;
    chk("abort_m_we", 32'(m_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_m_addr", 32'(m_addr), 32'd0);
    chk("abort_m_wdata", m_wdata, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr_n = 1'b1;
    chk("abort_mem", mem[4], 32'hCAFEBEEF);
    chk("abort_we_pulses", 32'(we_pulses - w0), 32'd0);

    // Tie right after reset release goes to port 0.
    drive(0, 1'b0, 2'b10, 12'h004, 32'd0);
    drive(1, 1'b0, 2'b10, 12'h00C, 32'd0);
    n = 0; cyc = 0;
    while (n == 0 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      if (done0 || done1) n = (done0 && done1) ? 3 : (done1 ? 2 : 1);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    chk("post_rst_winner", 32'(n), 32'd1);
    chk("post_rst_lat", 32'(cyc), 32'd2);
    chk("post_rst_rdata", rdata, 32'hDEADBEEF);

    wait_idle();
    chk("we_consecutive", 32'(we_consec), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
